// File: rtl/alu_cmd_driver.sv
// Host-side driver for the 2-bit-operand ALU tile: packs commands onto ui_in,
// waits a settle time, samples uo_out, checks it against a golden model and
// returns result/flags with running operation and mismatch counters.
// SETTLE_CYCLES must be in 1..15.
module alu_cmd_driver #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_a,
  input  logic [1:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_shamt,
  output logic [7:0]       alu_ui,
  input  logic [7:0]       alu_uo,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_mismatch,
  output logic [CNT_W-1:0] stat_ops,
  output logic [CNT_W-1:0] stat_err
);

  localparam int unsigned SC_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SC_W-1:0]   r_cnt;
  logic [7:0]        r_ui;
  logic              r_rsp_valid;
  logic [3:0]        r_result;
  logic [3:0]        r_flags;
  logic              r_mismatch;
  logic [CNT_W-1:0]  r_ops;
  logic [CNT_W-1:0]  r_err;

  logic              w_accept;
  logic              w_sample;
  logic              w_done;

  // Golden model operands are taken from the held tile byte.
  logic [1:0]        w_a;
  logic [1:0]        w_b;
  logic [2:0]        w_op;
  logic              w_sh;
  logic [7:0]        w_a8;
  logic [7:0]        w_b8;
  logic [7:0]        w_badd;
  logic              w_cin;
  logic [8:0]        w_sum;
  logic [7:0]        w_s;
  logic              w_cout;
  logic              w_is_and;
  logic [7:0]        w_r;
  logic              w_ovf;
  logic [7:0]        w_exp;

  assign w_a  = r_ui[1:0];
  assign w_b  = r_ui[3:2];
  assign w_op = r_ui[6:4];
  assign w_sh = r_ui[7];

  assign w_accept = cmd_valid && (r_state == S_IDLE);
  assign w_sample = (r_state == S_SETTLE) && (r_cnt == SC_W'(0));
  assign w_done   = (r_state == S_RESP) && rsp_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (cmd_valid) w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_cnt == SC_W'(0)) w_state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Golden model: expected tile output byte for the held command.
  always_comb begin
    w_a8     = {6'b0, w_a};
    w_b8     = {6'b0, w_b};
    w_cin    = (w_op == 3'b001) || (w_op == 3'b101) || (w_op == 3'b111);
    w_badd   = w_cin ? ~w_b8 : w_b8;
    w_sum    = 9'(w_a8) + 9'(w_badd) + 9'(w_cin);
    w_s      = w_sum[7:0];
    w_cout   = w_sum[8];
    w_is_and = (w_op == 3'b010);
    w_r      = w_s;
    case (w_op[2:1])
      2'b00:   w_r = w_s;
      2'b01:   w_r = w_op[0] ? (w_a8 | w_b8) : (w_a8 & w_b8);
      2'b10:   w_r = w_sh ? {w_s[6:0], 1'b0} : w_s;
      default: w_r = w_sh ? {1'b0, w_s[7:1]} : w_s;
    endcase
    w_ovf = w_s[7] & ~(w_a8[7] ^ w_b8[7] ^ w_cin) & ~w_is_and;
    w_exp = {w_ovf, w_r[7], (w_r == 8'h00), w_cout & ~w_is_and, w_r[3:0]};
  end

  // Command capture and settle countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ui  <= 8'h00;
      r_cnt <= SC_W'(0);
    end else if (w_accept) begin
      r_ui  <= {cmd_shamt, cmd_op, cmd_b, cmd_a};
      r_cnt <= SC_W'(SETTLE_CYCLES - 1);
    end else if ((r_state == S_SETTLE) && (r_cnt != SC_W'(0))) begin
      r_cnt <= r_cnt - SC_W'(1);
    end
  end

  // Response capture; data holds until the next sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_result    <= 4'h0;
      r_flags     <= 4'h0;
      r_mismatch  <= 1'b0;
    end else if (w_sample) begin
      r_rsp_valid <= 1'b1;
      r_result    <= alu_uo[3:0];
      r_flags     <= alu_uo[7:4];
      r_mismatch  <= (alu_uo != w_exp);
    end else if (w_done) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Saturating statistics, bumped on response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ops <= '0;
      r_err <= '0;
    end else if (w_done) begin
      if (r_ops != {CNT_W{1'b1}}) r_ops <= r_ops + CNT_W'(1);
      if (r_mismatch && (r_err != {CNT_W{1'b1}})) r_err <= r_err + CNT_W'(1);
    end
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign alu_ui       = r_ui;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_result;
  assign rsp_flags    = r_flags;
  assign rsp_mismatch = r_mismatch;
  assign stat_ops     = r_ops;
  assign stat_err     = r_err;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver with a behavioural tile/golden model.
module tb_alu_cmd_driver;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_a;
  logic [1:0]       cmd_b;
  logic [2:0]       cmd_op;
  logic             cmd_shamt;
  logic [7:0]       alu_ui;
  logic [7:0]       alu_uo;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_mismatch;
  logic [CNT_W-1:0] stat_ops;
  logic [CNT_W-1:0] stat_err;

  int checks   = 0;
  int failures = 0;
  int exp_ops  = 0;
  int exp_err  = 0;

  logic       use_ovr;
  logic [7:0] ovr_byte;
  logic [7:0] corrupt;

  always #5 clk = ~clk;

  // Arithmetic statement of the tile behaviour from the command byte.
  function automatic logic [7:0] ref_byte(input logic [7:0] ui);
    int a, b, op, sh, cin, s, cout, r, ovf, res;
    a   = int'(ui[1:0]);
    b   = int'(ui[3:2]);
    op  = int'(ui[6:4]);
    sh  = int'(ui[7]);
    cin = (op == 1 || op == 5 || op == 7) ? 1 : 0;
    s   = a + (cin != 0 ? 255 - b : b) + cin;
    cout = s / 256;
    s    = s % 256;
    case (op)
      0, 1:    r = s;
      2:       r = a & b;
      3:       r = a | b;
      4, 5:    r = (s * (1 << sh)) % 256;
      default: r = s / (1 << sh);
    endcase
    ovf = (s >= 128 && cin == 0 && op != 2) ? 1 : 0;
    res = (r % 16) + ((cout != 0 && op != 2) ? 16 : 0) + ((r == 0) ? 32 : 0)
        + ((r >= 128) ? 64 : 0) + (ovf != 0 ? 128 : 0);
    return 8'(res);
  endfunction

  assign alu_uo = use_ovr ? ovr_byte : (ref_byte(alu_ui) ^ corrupt);

  alu_cmd_driver #(.SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_op       (cmd_op),
    .cmd_shamt    (cmd_shamt),
    .alu_ui       (alu_ui),
    .alu_uo       (alu_uo),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .rsp_mismatch (rsp_mismatch),
    .stat_ops     (stat_ops),
    .stat_err     (stat_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; optionally offers the next command during the hold.
  task automatic send(input logic [1:0] a, input logic [1:0] b, input logic [2:0] op,
                      input logic sh, input int hold, input logic exp_mm,
                      input logic preload, input logic [7:0] nxt_ui);
    logic [7:0] ui;
    logic [7:0] exp_byte;
    int w;
    int bad;
    ui        = {sh, op, b, a};
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_shamt = sh;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      tick();
      w++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("alu_ui_pack", 32'(alu_ui), 32'(ui));
    w = 0;
    while (!rsp_valid && w < 50) begin
      tick();
      w++;
    end
    chk("rsp_latency", 32'(w), 32'(SETTLE));
    exp_byte = use_ovr ? ovr_byte : (ref_byte(ui) ^ corrupt);
    chk("rsp_result", 32'(rsp_result), 32'(exp_byte[3:0]));
    chk("rsp_flags", 32'(rsp_flags), 32'(exp_byte[7:4]));
    chk("rsp_mismatch", 32'(rsp_mismatch), 32'(exp_mm));
    if (preload) begin
      cmd_a     = nxt_ui[1:0];
      cmd_b     = nxt_ui[3:2];
      cmd_op    = nxt_ui[6:4];
      cmd_shamt = nxt_ui[7];
      cmd_valid = 1'b1;
    end
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_result !== exp_byte[3:0] || rsp_flags !== exp_byte[7:4] ||
          rsp_mismatch !== exp_mm || cmd_ready !== 1'b0 || alu_ui !== ui)
        bad++;
    end
    if (hold > 0) chk("hold_stable", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_ops++;
    if (exp_mm) exp_err++;
    chk("rsp_cleared", 32'(rsp_valid), 32'd0);
    chk("ready_after", 32'(cmd_ready), 32'd1);
    chk("ui_held", 32'(alu_ui), 32'(ui));
    chk("stat_ops", 32'(stat_ops), 32'(exp_ops));
    chk("stat_err", 32'(stat_err), 32'(exp_err));
  endtask

  initial begin
    int seen;
    logic [1:0] ra, rb;
    logic [2:0] rop;
    logic       rsh;
    logic [7:0] rui;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_a     = 2'd0;
    cmd_b     = 2'd0;
    cmd_op    = 3'd0;
    cmd_shamt = 1'b0;
    use_ovr   = 1'b0;
    ovr_byte  = 8'h00;
    corrupt   = 8'h00;

    // Reset state.
    tick();
    tick();
    chk("rst_alu_ui", 32'(alu_ui), 32'h00);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_flags", 32'(rsp_flags), 32'd0);
    chk("rst_mismatch", 32'(rsp_mismatch), 32'd0);
    chk("rst_ops", 32'(stat_ops), 32'd0);
    chk("rst_err", 32'(stat_err), 32'd0);
    rst = 1'b0;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Reset while settling discards the command.
    cmd_a = 2'd3; cmd_b = 2'd3; cmd_op = 3'd1; cmd_shamt = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("settle_ui", 32'(alu_ui), 32'h1F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("settle_rst_ui", 32'(alu_ui), 32'h00);
    chk("settle_rst_ready", 32'(cmd_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < int'(SETTLE) + 3; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    chk("settle_rst_no_rsp", 32'(seen), 32'd0);
    chk("settle_rst_ops", 32'(stat_ops), 32'd0);

    // Directed vectors with a fixed tile byte.
    use_ovr = 1'b1;
    ovr_byte = 8'h12;
    send(2'd3, 2'd1, 3'd1, 1'b0, 0, 1'b0, 1'b0, 8'h00);
    chk("dir_ui_0x17", 32'(alu_ui), 32'h17);
    ovr_byte = 8'h4F;
    send(2'd1, 2'd2, 3'd1, 1'b0, 1, 1'b0, 1'b0, 8'h00);
    ovr_byte = 8'h0F;
    send(2'd1, 2'd2, 3'd7, 1'b1, 0, 1'b0, 1'b0, 8'h00);
    ovr_byte = 8'h30;
    send(2'd2, 2'd2, 3'd1, 1'b0, 2, 1'b0, 1'b0, 8'h00);
    ovr_byte = 8'h00;
    send(2'd1, 2'd1, 3'd0, 1'b0, 0, 1'b1, 1'b0, 8'h00);

    // Backpressure for 10 cycles with the next command already offered.
    ovr_byte = 8'h02;
    send(2'd2, 2'd0, 3'd0, 1'b0, 10, 1'b0, 1'b1, {1'b0, 3'd3, 2'd1, 2'd2});
    ovr_byte = 8'h03;
    send(2'd2, 2'd1, 3'd3, 1'b0, 0, 1'b0, 1'b0, 8'h00);
    use_ovr = 1'b0;

    // Randomized commands against the reference tile, some corrupted.
    for (int n = 0; n < 150; n++) begin
      ra  = 2'($urandom_range(0, 3));
      rb  = 2'($urandom_range(0, 3));
      rop = 3'($urandom_range(0, 7));
      rsh = 1'($urandom_range(0, 1));
      rui = 8'($urandom_range(0, 255));
      corrupt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send(ra, rb, rop, rsh, $urandom_range(0, 3), (corrupt != 8'h00),
           1'b0, rui);
    end
    corrupt = 8'h00;

    // Reset while a response is held clears everything.
    cmd_a = 2'd1; cmd_b = 2'd0; cmd_op = 3'd0; cmd_shamt = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    seen = 0;
    while (!rsp_valid && seen < 50) begin
      tick();
      seen++;
    end
    chk("resp_reached", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b0;
    exp_ops = 0;
    exp_err = 0;
    chk("resp_rst_valid", 32'(rsp_valid), 32'd0);
    chk("resp_rst_ops", 32'(stat_ops), 32'd0);
    chk("resp_rst_err", 32'(stat_err), 32'd0);
    chk("resp_rst_ui", 32'(alu_ui), 32'h00);
    send(2'd3, 2'd2, 3'd5, 1'b1, 1, 1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Sequential host-side driver for the 2-bit-operand ALU tile's pin interface. It accepts ALU commands over a valid/ready channel and packs each one onto the tile's 8-bit `ui_in` byte. After a programmable settle time it samples the tile's 8-bit output byte and returns the result and flags over a valid/ready response channel. It also checks every response against a built-in golden model and keeps operation and mismatch counters for bring-up and silicon test.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles `alu_ui` is held before `alu_uo` is sampled. Legal range is 1..15; 0 is illegal.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `cmd_valid`  in  1  — a command is offered.
- `cmd_ready`  out  1  — the driver can accept a command.
- `cmd_a`  in  2  — operand A.
- `cmd_b`  in  2  — operand B.
- `cmd_op`  in  3  — ALU control code.
- `cmd_shamt`  in  1  — shift amount.
- `alu_ui`  out  8  — drives the ALU tile `ui_in`, packed as {shamt, op[2:0], b[1:0], a[1:0]}.
- `alu_uo`  in  8  — ALU tile output byte: [3:0] result nibble, [4] carry, [5] zero, [6] negative, [7] overflow.
- `rsp_valid`  out  1  — a response is held.
- `rsp_ready`  in  1  — the consumer accepts the response.
- `rsp_result`  out  4  — captured `alu_uo[3:0]`.
- `rsp_flags`  out  4  — captured `alu_uo[7:4]`.
- `rsp_mismatch`  out  1  — the captured byte differs from the golden model.
- `stat_ops`  out  CNT_W  — count of completed responses.
- `stat_err`  out  CNT_W  — count of responses with `rsp_mismatch=1`.

## Operation
- The FSM has three states: IDLE, SETTLE and RESP.
- `cmd_ready` = (state==IDLE).
- Transitions:
  - IDLE → SETTLE on `cmd_valid & cmd_ready`. The packed command is registered into `alu_ui`, the command fields are latched for the golden model, and the settle counter is loaded with `SETTLE_CYCLES-1`.
  - SETTLE, counter>0 → counter decrements.
  - SETTLE, counter==0 → RESP. At this edge `alu_uo` is registered into `rsp_result`/`rsp_flags`, `rsp_mismatch` is registered, and `rsp_valid` is set.
  - RESP → IDLE on `rsp_ready`. `rsp_valid` clears, `stat_ops` increments, and `stat_err` increments when `rsp_mismatch=1`.
- `alu_ui` changes only on command accept. It holds its value through SETTLE, RESP and IDLE, so the tile never sees an intermediate value.
- `rsp_*` data is stable while `rsp_valid=1`.
- Golden model. A and B are zero-extended to 8 bits; Cin = op ∈ {001,101,111}; S = A + (Cin ? ~B : B) + Cin, taken mod 256, with Cout being bit 8. The 8-bit result R is:
  - op 000/001 → S
  - op 010 → A&B
  - op 011 → A|B
  - op 100/101 → S<<shamt
  - op 110/111 → S>>shamt (logical)
- Golden flags: expected byte = {OVF, R[7], R==0, Cout & (op!=010), R[3:0]}, with OVF = S[7] & ~(A[7]^B[7]^Cin) & (op!=010).
- `rsp_mismatch` = (`alu_uo` != expected byte).
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset (`rst=1` at an edge): state=IDLE; `alu_ui`=0x00; `rsp_valid`=0; `rsp_result`=0; `rsp_flags`=0; `rsp_mismatch`=0; both counters=0. `cmd_ready`=1 from the first cycle after reset is deasserted.
- Reset mid-operation, in SETTLE or RESP: the pending response is discarded and the counters do not increment.
- Command accepted at edge N → `alu_ui` valid after N. `alu_uo` is sampled at edge N+`SETTLE_CYCLES`, and `rsp_valid`=1 after that edge.
- Response accepted at edge M → `cmd_ready`=1 after M. A new command can be accepted at edge M+1 at the earliest.
- Maximum throughput is one command per `SETTLE_CYCLES`+2 cycles.
- `cmd_valid` while `cmd_ready`=0 is ignored; the command is neither latched nor lost, and the source must hold it.
- `rsp_ready` while `rsp_valid`=0 has no effect.
- `cmd_valid` and `rsp_ready` high in the same cycle in RESP: only the response completes; the command is accepted in IDLE at the next edge.

## Test plan
- Reset with `rst`=1 for 2 cycles → `alu_ui`=0x00, `rsp_valid`=0, counters 0, `cmd_ready`=1 on the first post-reset cycle.
- Command a=3, b=1, op=001, SETTLE_CYCLES=2, tile model returns 0x12 → `alu_ui`=0x17. `rsp_valid` rises 2 cycles after accept with result=0x2, flags=0x1, mismatch=0; `stat_ops`=1 after handshake.
- Command a=1, b=2, op=001 → expected byte 0x4F. Command a=1, b=2, op=111, shamt=1 → expected 0x0F. Command a=2, b=2, op=001 → expected 0x30. All return mismatch=0.
- Tile model forced to return 0x00 for a=1, b=1, op=000 (expected 0x02) → mismatch=1 and `stat_err` increments by 1.
- Hold `rsp_ready`=0 for 10 cycles with `cmd_valid`=1 → `rsp_*` stable, `cmd_ready`=0, `alu_ui` unchanged. Release → exactly one response completes, then the next command is accepted one cycle later.
- Assert `rst` in SETTLE → `rsp_valid` never rises, `stat_ops` stays 0, `alu_ui`=0x00.
